// File: rtl/sop_pipe.sv
// sop_pipe: two-stage registered two-level logic evaluator.
// Stage 1 holds the per-group first-level results and the item's own mode.
// Stage 2 holds the final reduction and is the output register.
// Valid/ready on both sides with full backpressure, plus a saturating
// counter of accepted outputs whose result was 1.
module sop_pipe #(
  parameter int GROUPS = 2,
  parameter int TERM_W = 2,
  parameter int CNT_W  = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [GROUPS*TERM_W-1:0]   in_data,
  input  logic [1:0]                 mode,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic                       out,
  output logic [GROUPS-1:0]          out_terms,
  output logic                       out_valid,
  input  logic                       out_ready,
  input  logic                       clr_count,
  output logic [CNT_W-1:0]           hit_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [GROUPS-1:0] term_next;
  logic [GROUPS-1:0] s1_terms_reg;
  logic [1:0]        s1_mode_reg;
  logic              s1_valid_reg;
  logic              out_next;
  logic              out_reg;
  logic [GROUPS-1:0] out_terms_reg;
  logic              out_valid_reg;
  logic [CNT_W-1:0]  hit_count_reg;

  logic s2_accept;
  logic in_fire;
  logic s1_advance;
  logic out_fire;

  // Handshake: stage 2 frees when empty or being drained; stage 1 frees
  // when empty or moving into stage 2 this cycle.
  assign s2_accept  = !out_valid_reg || out_ready;
  assign in_ready   = !s1_valid_reg || s2_accept;
  assign in_fire    = in_valid && in_ready;
  assign s1_advance = s1_valid_reg && s2_accept;
  assign out_fire   = out_valid_reg && out_ready;

  // First level: one reduction per group, chosen by the incoming mode.
  // AND is shared by modes 00 and 11.
  for (genvar gi = 0; gi < GROUPS; gi++) begin : g_term
    logic [TERM_W-1:0] grp_bits;
    assign grp_bits = in_data[gi*TERM_W +: TERM_W];
    assign term_next[gi] = (mode == 2'b01) ? (|grp_bits) :
                           (mode == 2'b10) ? (^grp_bits) :
                                             (&grp_bits);
  end

  // Second level across the stage-1 terms, using the mode stored with the item.
  always_comb begin
    out_next = 1'b0;
    case (s1_mode_reg)
      2'b00:   out_next = |s1_terms_reg;
      2'b01:   out_next = &s1_terms_reg;
      2'b10:   out_next = ^s1_terms_reg;
      default: out_next = &s1_terms_reg;
    endcase
  end

  // Stage 1: load only on an input handshake so idle/X data never enters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_terms_reg <= '0;
      s1_mode_reg  <= 2'b00;
      s1_valid_reg <= 1'b0;
    end else begin
      if (in_fire) begin
        s1_terms_reg <= term_next;
        s1_mode_reg  <= mode;
        s1_valid_reg <= 1'b1;
      end else if (s1_advance) begin
        s1_valid_reg <= 1'b0;
      end
    end
  end

  // Stage 2 (output): capture when stage 1 is full and there is room,
  // otherwise hold while stalled or drop valid once drained.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_reg       <= 1'b0;
      out_terms_reg <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      if (s1_advance) begin
        out_reg       <= out_next;
        out_terms_reg <= s1_terms_reg;
        out_valid_reg <= 1'b1;
      end else if (out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  // Hit counter: clear has priority, increments stop at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_count_reg <= '0;
    end else if (clr_count) begin
      hit_count_reg <= '0;
    end else if (out_fire && out_reg && (hit_count_reg != CNT_MAX)) begin
      hit_count_reg <= hit_count_reg + CNT_ONE;
    end
  end

  assign out       = out_reg;
  assign out_terms = out_terms_reg;
  assign out_valid = out_valid_reg;
  assign hit_count = hit_count_reg;

endmodule

// File: tb/tb_sop_pipe.sv
// tb_sop_pipe: directed stimulus with a scoreboard queue. The driver pushes
// the hand-computed result of each accepted item; the monitor pops and
// compares on every output handshake. A second instance with a 2-bit
// counter shares all inputs and is used for the saturation checks.
module tb_sop_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] in_data;
  logic [1:0] mode;
  logic       in_valid;
  logic       in_ready;
  logic       out;
  logic [1:0] out_terms;
  logic       out_valid;
  logic       out_ready;
  logic       clr_count;
  logic [7:0] hit_count;

  logic       in_ready_c;
  logic       out_c;
  logic [1:0] out_terms_c;
  logic       out_valid_c;
  logic [1:0] hit_count_c;

  int errors = 0;
  int checks = 0;
  int accepted = 0;
  logic [2:0] exp_q[$];

  logic [15:0] sop_out = 16'b1111_1000_1000_1000;
  logic [1:0]  sop_terms [16] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd1,
                                  2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd3};

  always #5 clk = ~clk;

  sop_pipe #(.GROUPS(2), .TERM_W(2), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready), .out(out),
    .out_terms(out_terms), .out_valid(out_valid), .out_ready(out_ready),
    .clr_count(clr_count), .hit_count(hit_count)
  );

  sop_pipe #(.GROUPS(2), .TERM_W(2), .CNT_W(2)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready_c), .out(out_c),
    .out_terms(out_terms_c), .out_valid(out_valid_c), .out_ready(out_ready),
    .clr_count(clr_count), .hit_count(hit_count_c)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // Drive one item, wait (bounded) for acceptance, record its expected result.
  task automatic send(input logic [3:0] d, input logic [1:0] m,
                      input logic eo, input logic [1:0] et);
    int n = 0;
    in_data  = d;
    mode     = m;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready=0 expected 1 for data %0h", d);
    end else begin
      exp_q.push_back({eo, et});
      accepted++;
      $display("send data=%b mode=%b expect out=%b terms=%b", d, m, eo, et);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = ~d;
    mode     = ~m;
  endtask

  // Wait (bounded) until every expected item has been delivered.
  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clear();
    clr_count = 1'b1;
    @(posedge clk);
    #1;
    clr_count = 1'b0;
  endtask

  // Monitor: compare every output handshake against the queue head.
  initial begin
    logic [2:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got out=%b terms=%b expected no item", out, out_terms);
        end else begin
          e = exp_q.pop_front();
          check("out", {31'd0, out}, {31'd0, e[2]});
          check("out_terms", {30'd0, out_terms}, {30'd0, e[1:0]});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 4'hF;
    mode      = 2'b11;
    out_ready = 1'b1;
    clr_count = 1'b0;

    // Reset held 3 cycles with a valid item offered: nothing may load.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out", {31'd0, out}, 32'd0);
      check("rst_hit_count", {24'd0, hit_count}, 32'd0);
    end
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;

    // Latency: accepted at edge N, visible after edge N+1.
    send(4'b0011, 2'b00, 1'b1, 2'b01);
    @(negedge clk);
    check("latency_not_yet", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    check("latency_valid", {31'd0, out_valid}, 32'd1);
    drain();
    pulse_clear();
    check("clr_hit_count", {24'd0, hit_count}, 32'd0);

    // Sum-of-products truth table, back-to-back.
    for (int i = 0; i < 16; i++) begin
      send(4'(i), 2'b00, sop_out[i], sop_terms[i]);
    end
    drain();
    check("sop_hit_count", {24'd0, hit_count}, 32'd7);
    check("sop_hit_count_sat2", {30'd0, hit_count_c}, 32'd3);
    pulse_clear();

    // Mode sweep on a single data pattern.
    send(4'b0110, 2'b00, 1'b0, 2'b00);
    send(4'b0110, 2'b01, 1'b1, 2'b11);
    send(4'b0110, 2'b10, 1'b0, 2'b11);
    send(4'b0110, 2'b11, 1'b0, 2'b00);
    drain();
    check("mode_hit_count", {24'd0, hit_count}, 32'd1);
    pulse_clear();

    // Saturation: 5 hits on the 2-bit counter stop at 3.
    for (int i = 0; i < 5; i++) begin
      send(4'b1111, 2'b11, 1'b1, 2'b11);
    end
    drain();
    check("five_hits", {24'd0, hit_count}, 32'd5);
    check("five_hits_sat2", {30'd0, hit_count_c}, 32'd3);

    // Clear coincident with a hit handshake: clear wins.
    out_ready = 1'b0;
    send(4'b1111, 2'b11, 1'b1, 2'b11);
    @(posedge clk);
    #1;
    check("held_for_clr", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    clr_count = 1'b1;
    @(posedge clk);
    #1;
    clr_count = 1'b0;
    check("clr_vs_hit", {24'd0, hit_count}, 32'd0);
    check("clr_vs_hit_sat2", {30'd0, hit_count_c}, 32'd0);
    drain();

    // Backpressure: 4 items offered, downstream stalled for 5 cycles.
    accepted  = 0;
    out_ready = 1'b0;
    fork
      begin
        send(4'b0011, 2'b00, 1'b1, 2'b01);
        send(4'b1100, 2'b00, 1'b1, 2'b10);
        send(4'b0110, 2'b01, 1'b1, 2'b11);
        send(4'b0000, 2'b00, 1'b0, 2'b00);
      end
      begin
        for (int c = 1; c <= 5; c++) begin
          @(negedge clk);
          if (c >= 3) begin
            check("bp_hold_out", {31'd0, out}, 32'd1);
            check("bp_hold_terms", {30'd0, out_terms}, 32'd1);
            check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
          end
        end
        check("bp_accepted", accepted, 32'd2);
        check("bp_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    check("bp_delivered", accepted, 32'd4);
    check("bp_hit_count", {24'd0, hit_count}, 32'd3);

    // Reset with two items in flight: both discarded.
    out_ready = 1'b0;
    send(4'b1111, 2'b11, 1'b1, 2'b11);
    send(4'b1111, 2'b11, 1'b1, 2'b11);
    check("midrst_full", {31'd0, in_ready}, 32'd0);
    rst_n = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_hit_count", {24'd0, hit_count}, 32'd0);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    repeat (6) @(negedge clk);
    check("midrst_no_emit_hits", {24'd0, hit_count}, 32'd0);
    check("queue_empty", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
